// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage with PC register and req/ack imem handshake.
//   clk, reset          : clock, synchronous active-high reset
//   imem_req/addr       : request and word address to instruction memory (held until ack)
//   imem_ack/rdata      : completion strobe and instruction word from memory
//   instr/pc/pcplus4    : registered instruction, its address, and pc+4 link value
//   instr_valid/ready   : handshake with decode; redirects sampled on valid & ready
//   pcsrc/jump/jr       : branch / jump / jump-register redirect controls
//   signimm/jr_target   : branch immediate and jr register value
//   misalign            : sticky flag for a jr target with nonzero low bits
//   instr_count         : instructions consumed since reset (wraps)
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic [31:0] pcplus4,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        pcsrc,
   input  logic        jump,
   input  logic        jr,
   input  logic [31:0] signimm,
   input  logic [31:0] jr_target,
   output logic        misalign,
   output logic [31:0] instr_count
);
   typedef enum logic [1:0] {BOOT, REQ, VALID} state_t;
   state_t state, state_n;
   logic consume;
   logic [31:0] next_pc;
   assign imem_req = state == REQ;
   assign imem_addr = pc;
   assign instr_valid = state == VALID;
   assign pcplus4 = pc + 32'd4;
   assign consume = instr_valid & instr_ready;
   always_ff @(posedge clk)
      state <= reset ? BOOT : state_n;
   always_comb begin
      state_n = state;
      state_n = state == BOOT ? REQ :
                state == REQ  ? (imem_ack ? VALID : REQ) :
                                (instr_ready ? REQ : VALID);
   end
   // redirect priority: jr > jump > taken branch > sequential
   always_comb begin
      next_pc = pcplus4;
      next_pc = jr    ? {jr_target[31:2], 2'b00} :
                jump  ? {pcplus4[31:28], instr[25:0], 2'b00} :
                pcsrc ? pcplus4 + {signimm[29:0], 2'b00} : pcplus4;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= RESET_PC;
         instr <= '0;
         misalign <= 1'b0;
         instr_count <= '0;
      end else begin
         if (imem_req & imem_ack) instr <= imem_rdata;
         if (consume) begin
            pc <= next_pc;
            instr_count <= instr_count + 32'd1;
            if (jr & |jr_target[1:0]) misalign <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plus randomized checks of fetch_unit against a PC/count model.
module tb_fetch_unit;
   localparam logic [31:0] RPC = 32'h0040_0000;
   logic clk = 1'b0, reset = 1'b0;
   logic imem_req, imem_ack = 1'b0, instr_valid, instr_ready = 1'b0, misalign;
   logic pcsrc = 1'b0, jump = 1'b0, jr = 1'b0;
   logic [31:0] imem_addr, imem_rdata = '0, instr, pc, pcplus4, instr_count;
   logic [31:0] signimm = '0, jr_target = '0;
   int n_cmp = 0, n_err = 0;
   logic [31:0] exp_pc, exp_instr, exp_count;
   logic exp_mis;

   fetch_unit #(.RESET_PC(RPC)) dut (
      .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .pc(pc),
      .pcplus4(pcplus4), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .pcsrc(pcsrc), .jump(jump), .jr(jr), .signimm(signimm), .jr_target(jr_target),
      .misalign(misalign), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // architectural next-PC rule, written as plain arithmetic
   function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] ins,
         input logic b, input logic j, input logic r, input logic [31:0] imm, input logic [31:0] t);
      logic [31:0] seq;
      seq = p + 32'd4;
      if (r) return t - (t % 4);
      if (j) return (seq & 32'hF000_0000) + (ins % 32'h0400_0000) * 4;
      if (b) return seq + imm * 4;
      return seq;
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_pc = RPC; exp_count = 0; exp_mis = 1'b0; exp_instr = 0;
      chk("rst_pc", pc, RPC);
      chk("rst_instr", instr, 0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_req", imem_req, 0);
      chk("rst_mis", misalign, 0);
      chk("rst_cnt", instr_count, 0);
   endtask

   task automatic fetch(input int lat, input logic [31:0] data);
      int k = 0;
      while (!imem_req && k < 4) begin tick(); k++; end
      chk("req_seen", imem_req, 1);
      chk("req_addr", imem_addr, exp_pc);
      for (int i = 0; i < lat; i++) begin
         tick();
         chk("wait_req", imem_req, 1);
         chk("wait_addr", imem_addr, exp_pc);
         chk("wait_valid", instr_valid, 0);
      end
      imem_ack = 1'b1; imem_rdata = data;
      tick();
      imem_ack = 1'b0; imem_rdata = $urandom;
      exp_instr = data;
      chk("valid", instr_valid, 1);
      chk("req_drop", imem_req, 0);
      chk("instr", instr, exp_instr);
      chk("pc", pc, exp_pc);
      chk("pcplus4", pcplus4, exp_pc + 32'd4);
   endtask

   task automatic consume(input int w, input logic b, input logic j, input logic r,
         input logic [31:0] imm, input logic [31:0] t);
      for (int i = 0; i < w; i++) begin
         imem_ack = 1'($urandom_range(0, 1));
         tick();
         chk("hold_valid", instr_valid, 1);
         chk("hold_req", imem_req, 0);
         chk("hold_pc", pc, exp_pc);
         chk("hold_instr", instr, exp_instr);
      end
      imem_ack = 1'b0;
      instr_ready = 1'b1; pcsrc = b; jump = j; jr = r; signimm = imm; jr_target = t;
      tick();
      instr_ready = 1'b0; pcsrc = $urandom; jump = $urandom; jr = $urandom;
      signimm = $urandom; jr_target = $urandom;
      exp_pc = ref_next(exp_pc, exp_instr, b, j, r, imm, t);
      exp_count = exp_count + 1;
      if (r && (t % 4 != 0)) exp_mis = 1'b1;
      chk("cons_valid", instr_valid, 0);
      chk("cons_req", imem_req, 1);
      chk("next_addr", imem_addr, exp_pc);
      chk("count", instr_count, exp_count);
      chk("misalign", misalign, exp_mis);
   endtask

   initial begin
      reset = 1'b1; imem_ack = 1'b1;
      tick();
      do_reset();
      // sequential zero-wait fetches
      for (int i = 0; i < 3; i++) begin
         fetch(0, $urandom);
         consume(0, 0, 0, 0, 0, 0);
      end
      chk("seq_addr3", imem_addr, 32'h0040_000C);
      chk("seq_cnt3", instr_count, 3);
      // slow memory and stalled decode
      fetch(3, $urandom);
      consume(5, 0, 0, 0, 0, 0);
      // taken backward branch from 0x100
      fetch(0, $urandom);
      consume(0, 0, 0, 1, 0, 32'h0000_0100);
      fetch(1, $urandom);
      consume(0, 1, 0, 0, 32'hFFFF_FFFE, 0);
      chk("br_addr", imem_addr, 32'h0000_00FC);
      // jump from 0x1000_0000
      fetch(0, $urandom);
      consume(0, 0, 0, 1, 0, 32'h1000_0000);
      fetch(0, 32'h0800_0010);
      consume(0, 1, 1, 0, 0, 0);
      chk("j_addr", imem_addr, 32'h1000_0040);
      // jr beats jump and pcsrc, misaligned target sets sticky flag
      fetch(2, $urandom);
      consume(0, 1, 1, 1, 32'h10, 32'h0000_2003);
      chk("jr_addr", imem_addr, 32'h0000_2000);
      chk("jr_mis", misalign, 1);
      fetch(0, $urandom);
      consume(1, 0, 0, 0, 0, 0);
      chk("mis_sticky", misalign, 1);
      // pc wrap at top of address space
      fetch(0, $urandom);
      consume(0, 0, 0, 1, 0, 32'hFFFF_FFFC);
      fetch(0, $urandom);
      chk("wrap_p4", pcplus4, 0);
      consume(0, 0, 0, 0, 0, 0);
      chk("wrap_addr", imem_addr, 0);
      // instruction counter wrap
      fetch(0, $urandom);
      force dut.instr_count = 32'hFFFF_FFFE;
      #1 release dut.instr_count;
      exp_count = 32'hFFFF_FFFE;
      consume(0, 0, 0, 0, 0, 0);
      fetch(0, $urandom);
      consume(0, 0, 0, 0, 0, 0);
      chk("cnt_wrap", instr_count, 0);
      // randomized traffic
      for (int i = 0; i < 40; i++) begin
         fetch($urandom_range(0, 3), $urandom);
         consume($urandom_range(0, 2), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 4) == 0), $urandom_range(0, 255) - 128, $urandom);
      end
      // reset mid-request, late ack during BOOT ignored
      while (!imem_req) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      chk("boot_req", imem_req, 0);
      chk("boot_valid", instr_valid, 0);
      tick();
      imem_ack = 1'b0;
      chk("post_valid", instr_valid, 0);
      chk("post_req", imem_req, 1);
      chk("post_addr", imem_addr, RPC);
      chk("post_instr", instr, 0);
      chk("post_mis", misalign, 0);
      chk("post_cnt", instr_count, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
